// File: rtl/executor_pkg.sv
// Shared constants for the accumulator CPU execute stage.
// No logic; types and defaults only.
// Imported by executor and exec_alu.
package executor_pkg;

    localparam int BITS_DEF  = 8;
    localparam int NREGS_DEF = 8;

    // ALU function codes carried in the imm field of an ALU instruction
    typedef enum logic [2:0] {
        ALU_ADD  = 3'd0,
        ALU_SUB  = 3'd1,
        ALU_AND  = 3'd2,
        ALU_OR   = 3'd3,
        ALU_XOR  = 3'd4,
        ALU_SHL  = 3'd5,
        ALU_SHR  = 3'd6,
        ALU_MOVR = 3'd7
    } alu_fn_t;

    // Executor FSM encoding
    typedef enum logic [1:0] {
        EXEC_IDLE     = 2'd0,
        EXEC_MEM_ADDR = 2'd1,
        EXEC_MEM_DATA = 2'd2
    } exec_state_t;

endpackage

// File: rtl/exec_alu.sv
// Combinational ALU for the execute stage.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; caller decides when to commit the result.
module exec_alu
    import executor_pkg::*;
#(
    parameter int BITS = BITS_DEF
) (
    input  logic [BITS-1:0] acc,
    input  logic [BITS-1:0] operand,
    input  alu_fn_t         fn,
    input  logic            c_in,
    output logic [BITS-1:0] result,
    output logic            c_out,
    output logic            write_acc,
    output logic            write_reg
);

    logic [BITS:0] sum;

    // Decode function code into result, carry and write targets
    always_comb begin
        result    = acc;
        c_out     = c_in;
        write_acc = 1'b1;
        write_reg = 1'b0;
        sum       = '0;
        case (fn)
            ALU_ADD: begin
                sum    = {1'b0, acc} + {1'b0, operand};
                result = sum[BITS-1:0];
                c_out  = sum[BITS];
            end
            ALU_SUB: begin
                // top bit of the widened difference is the borrow (acc < operand)
                sum    = {1'b0, acc} - {1'b0, operand};
                result = sum[BITS-1:0];
                c_out  = sum[BITS];
            end
            ALU_AND: begin
                result = acc & operand;
                c_out  = 1'b0;
            end
            ALU_OR: begin
                result = acc | operand;
                c_out  = 1'b0;
            end
            ALU_XOR: begin
                result = acc ^ operand;
                c_out  = 1'b0;
            end
            ALU_SHL: begin
                result = {acc[BITS-2:0], 1'b0};
                c_out  = acc[BITS-1];
            end
            ALU_SHR: begin
                result = {1'b0, acc[BITS-1:1]};
                c_out  = acc[0];
            end
            ALU_MOVR: begin
                // accumulator copied into the register file; acc and flags untouched
                write_acc = 1'b0;
                write_reg = 1'b1;
            end
            default: begin
                result = acc;
            end
        endcase
    end

endmodule

// File: rtl/executor.sv
// Execute stage: accumulator, 8-entry register file, Z/C flags, two-phase memory bus.
// Latency: ALU/LDI 1 cycle start-to-done; memory ops 3 cycles plus one per mem_ack-low cycle.
// Backpressure: mem_ack stalls each bus phase; start is ignored while busy.
module executor
    import executor_pkg::*;
#(
    parameter int BITS  = BITS_DEF,
    parameter int NREGS = NREGS_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            is_alu_op,
    input  logic            is_mem_op,
    input  logic            mem_rw,
    input  logic [2:0]      imm,
    input  logic [2:0]      register,
    input  logic [BITS-1:0] data_in,
    input  logic            mem_ack,
    output logic [BITS-1:0] acc,
    output logic            flag_z,
    output logic            flag_c,
    output logic            busy,
    output logic            done,
    output logic            mem_req,
    output logic            mem_we,
    output logic            addr_data,
    output logic [BITS-1:0] bus_out
);

    exec_state_t     state, state_nxt;
    logic [BITS-1:0] regs [NREGS];
    logic            rw_q, rw_nxt;

    logic [BITS-1:0] acc_nxt, bus_nxt;
    logic            z_nxt, c_nxt, done_nxt, req_nxt, we_nxt, ad_nxt;
    logic            reg_we;

    logic [BITS-1:0] alu_result;
    logic            alu_c_out, alu_write_acc, alu_write_reg;

    exec_alu #(.BITS(BITS)) u_alu (
        .acc       (acc),
        .operand   (regs[register]),
        .fn        (alu_fn_t'(imm)),
        .c_in      (flag_c),
        .result    (alu_result),
        .c_out     (alu_c_out),
        .write_acc (alu_write_acc),
        .write_reg (alu_write_reg)
    );

    assign busy = (state != EXEC_IDLE);

    // Next-state and next-output decode; everything holds unless a rule below fires
    always_comb begin
        state_nxt = state;
        rw_nxt    = rw_q;
        acc_nxt   = acc;
        z_nxt     = flag_z;
        c_nxt     = flag_c;
        done_nxt  = 1'b0;
        req_nxt   = mem_req;
        we_nxt    = mem_we;
        ad_nxt    = addr_data;
        bus_nxt   = bus_out;
        reg_we    = 1'b0;
        case (state)
            EXEC_IDLE: begin
                if (start) begin
                    if (is_mem_op) begin
                        // address phase: present R[r] on the bus
                        state_nxt = EXEC_MEM_ADDR;
                        rw_nxt    = mem_rw;
                        req_nxt   = 1'b1;
                        ad_nxt    = 1'b0;
                        we_nxt    = 1'b0;
                        bus_nxt   = regs[register];
                    end else if (is_alu_op) begin
                        done_nxt = 1'b1;
                        c_nxt    = alu_c_out;
                        reg_we   = alu_write_reg;
                        if (alu_write_acc) begin
                            acc_nxt = alu_result;
                            z_nxt   = (alu_result == '0);
                        end
                    end else begin
                        // LDI: zero-extended immediate, carry untouched
                        done_nxt = 1'b1;
                        acc_nxt  = {{(BITS-3){1'b0}}, imm};
                        z_nxt    = (imm == 3'd0);
                    end
                end
            end
            EXEC_MEM_ADDR: begin
                if (mem_ack) begin
                    state_nxt = EXEC_MEM_DATA;
                    ad_nxt    = 1'b1;
                    we_nxt    = rw_q;
                    bus_nxt   = rw_q ? acc : '0;
                end
            end
            EXEC_MEM_DATA: begin
                if (mem_ack) begin
                    if (!rw_q) begin
                        acc_nxt = data_in;
                        z_nxt   = (data_in == '0);
                    end
                    state_nxt = EXEC_IDLE;
                    req_nxt   = 1'b0;
                    we_nxt    = 1'b0;
                    ad_nxt    = 1'b0;
                    done_nxt  = 1'b1;
                end
            end
            default: begin
                state_nxt = EXEC_IDLE;
                req_nxt   = 1'b0;
                we_nxt    = 1'b0;
                ad_nxt    = 1'b0;
            end
        endcase
    end

    // State, accumulator, flags and bus outputs register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= EXEC_IDLE;
            rw_q      <= 1'b0;
            acc       <= '0;
            flag_z    <= 1'b0;
            flag_c    <= 1'b0;
            done      <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            addr_data <= 1'b0;
            bus_out   <= '0;
        end else begin
            state     <= state_nxt;
            rw_q      <= rw_nxt;
            acc       <= acc_nxt;
            flag_z    <= z_nxt;
            flag_c    <= c_nxt;
            done      <= done_nxt;
            mem_req   <= req_nxt;
            mem_we    <= we_nxt;
            addr_data <= ad_nxt;
            bus_out   <= bus_nxt;
        end
    end

    // Register file; only MOVR writes it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (reg_we) begin
            regs[register] <= acc;
        end
    end

endmodule

// File: tb/tb_executor.sv
module tb_executor;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       is_alu_op = 1'b0;
    logic       is_mem_op = 1'b0;
    logic       mem_rw = 1'b0;
    logic [2:0] imm = 3'd0;
    logic [2:0] register = 3'd0;
    logic [7:0] data_in = 8'd0;
    logic       mem_ack = 1'b0;
    logic [7:0] acc;
    logic       flag_z, flag_c, busy, done, mem_req, mem_we, addr_data;
    logic [7:0] bus_out;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    executor dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .is_alu_op (is_alu_op),
        .is_mem_op (is_mem_op),
        .mem_rw    (mem_rw),
        .imm       (imm),
        .register  (register),
        .data_in   (data_in),
        .mem_ack   (mem_ack),
        .acc       (acc),
        .flag_z    (flag_z),
        .flag_c    (flag_c),
        .busy      (busy),
        .done      (done),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .addr_data (addr_data),
        .bus_out   (bus_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Architectural state plus a phase number: 0 = idle, 1 = address, 2 = data.
    int m_acc, m_z, m_c, m_phase, m_rw, m_addr, m_done;
    int m_regs [8];

    task automatic model_exec(input int fn, input int r, input bit alu);
        int a, b, s;
        a = m_acc;
        b = m_regs[r];
        if (!alu) begin
            m_acc = fn;
            m_z   = (m_acc == 0);
            return;
        end
        case (fn)
            0: begin s = a + b; m_c = (s > 255); m_acc = s % 256; end
            1: begin m_c = (a < b); m_acc = (a - b + 256) % 256; end
            2: begin m_acc = a & b; m_c = 0; end
            3: begin m_acc = a | b; m_c = 0; end
            4: begin m_acc = a ^ b; m_c = 0; end
            5: begin m_c = a / 128; m_acc = (a * 2) % 256; end
            6: begin m_c = a % 2; m_acc = a / 2; end
            default: begin m_regs[r] = a; return; end
        endcase
        m_z = (m_acc == 0);
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_acc = 0; m_z = 0; m_c = 0; m_phase = 0; m_rw = 0; m_addr = 0; m_done = 0;
            for (int i = 0; i < 8; i++) m_regs[i] = 0;
        end else begin
            m_done = 0;
            case (m_phase)
                0: if (start) begin
                    if (is_mem_op) begin
                        m_phase = 1;
                        m_rw    = mem_rw;
                        m_addr  = m_regs[register];
                    end else begin
                        m_done = 1;
                        model_exec(int'(imm), int'(register), is_alu_op);
                    end
                end
                1: if (mem_ack) m_phase = 2;
                default: if (mem_ack) begin
                    if (m_rw == 0) begin
                        m_acc = data_in;
                        m_z   = (data_in == 0);
                    end
                    m_phase = 0;
                    m_done  = 1;
                end
            endcase
        end
    end

    // Compare DUT outputs with the model on every falling edge
    always @(negedge clk) begin
        if (chk_en) begin
            check("acc", acc, m_acc);
            check("flag_z", flag_z, m_z);
            check("flag_c", flag_c, m_c);
            check("done", done, m_done);
            check("busy", busy, m_phase != 0);
            check("mem_req", mem_req, m_phase != 0);
            check("addr_data", addr_data, m_phase == 2);
            check("mem_we", mem_we, (m_phase == 2) && (m_rw == 1));
            if (m_phase == 1) check("bus_addr", bus_out, m_addr);
            if (m_phase == 2) check("bus_data", bus_out, m_rw ? m_acc : 0);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic next_cycle();
        @(negedge clk);
        #1;
    endtask

    // Drive one start cycle; returns in the following cycle with outputs settled
    task automatic issue(input bit m, input bit a, input bit rw, input int i, input int r);
        next_cycle();
        start     = 1'b1;
        is_mem_op = m;
        is_alu_op = a;
        mem_rw    = rw;
        imm       = 3'(i);
        register  = 3'(r);
        next_cycle();
        start     = 1'b0;
        is_mem_op = 1'($urandom);
        is_alu_op = 1'($urandom);
        mem_rw    = 1'($urandom);
        imm       = 3'($urandom);
        register  = 3'($urandom);
    endtask

    task automatic ldi(input int v);
        issue(0, 0, 0, v, 0);
    endtask

    task automatic alu(input int fn, input int r);
        issue(0, 1, 0, fn, r);
    endtask

    int done_cnt;

    initial begin
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_acc", acc, 8'h00);
        check("rst_z", flag_z, 1'b0);
        check("rst_c", flag_c, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_req", mem_req, 1'b0);
        check("rst_busy", busy, 1'b0);
        next_cycle();
        reset  = 1'b1;
        chk_en = 1'b1;

        // LDI 5, MOVR r2, LDI 7, ADD r2 -> 0x0C
        ldi(5);
        check("ldi5_done", done, 1'b1);
        check("ldi5_acc", acc, 8'h05);
        alu(7, 2);
        check("movr_done", done, 1'b1);
        ldi(7);
        alu(0, 2);
        check("add_acc", acc, 8'h0C);
        check("add_c", flag_c, 1'b0);
        check("add_z", flag_z, 1'b0);
        check("add_done", done, 1'b1);
        next_cycle();
        check("done_1cyc", done, 1'b0);

        // R1=1, acc=0xFF, ADD -> 0 with carry, SUB -> 0xFF with borrow
        ldi(1);
        alu(7, 1);
        ldi(0);
        alu(1, 1);
        check("sub0_acc", acc, 8'hFF);
        alu(0, 1);
        check("wrap_acc", acc, 8'h00);
        check("wrap_c", flag_c, 1'b1);
        check("wrap_z", flag_z, 1'b1);
        alu(1, 1);
        check("borrow_acc", acc, 8'hFF);
        check("borrow_c", flag_c, 1'b1);

        // R3=0x40, R4=5, acc=0xA5
        ldi(1);
        repeat (6) alu(5, 0);
        alu(7, 3);
        ldi(5);
        alu(7, 4);
        ldi(5);
        repeat (5) alu(5, 0);
        alu(3, 4);
        check("a5_acc", acc, 8'hA5);

        // Store r3 with mem_ack held high
        mem_ack = 1'b1;
        issue(1, 0, 1, 0, 3);
        check("st_c1_req", mem_req, 1'b1);
        check("st_c1_ad", addr_data, 1'b0);
        check("st_c1_bus", bus_out, 8'h40);
        check("st_c1_we", mem_we, 1'b0);
        next_cycle();
        check("st_c2_ad", addr_data, 1'b1);
        check("st_c2_we", mem_we, 1'b1);
        check("st_c2_bus", bus_out, 8'hA5);
        next_cycle();
        check("st_c3_done", done, 1'b1);
        check("st_c3_req", mem_req, 1'b0);

        // Carry set by SHL of 0xA5, then load r3 with two wait cycles per phase
        alu(5, 0);
        check("shl_c", flag_c, 1'b1);
        mem_ack = 1'b0;
        data_in = 8'h00;
        issue(1, 0, 0, 0, 3);
        for (int k = 1; k <= 6; k++) begin
            mem_ack = (k == 3 || k == 6);
            check("ld_wait_done", done, 1'b0);
            next_cycle();
        end
        mem_ack = 1'b0;
        check("ld_c7_done", done, 1'b1);
        check("ld_acc", acc, 8'h00);
        check("ld_z", flag_z, 1'b1);
        check("ld_c", flag_c, 1'b1);

        // start pulses during a store must be ignored
        issue(1, 0, 1, 0, 3);
        done_cnt = 0;
        for (int k = 1; k <= 9; k++) begin
            if (done) done_cnt++;
            start     = (k <= 4) && (k % 2 == 1 || k == 4);
            is_mem_op = (k == 3);
            is_alu_op = 1'b0;
            imm       = 3'd6;
            register  = 3'(k);
            mem_ack   = (k >= 5);
            next_cycle();
        end
        mem_ack = 1'b0;
        check("ignore_done_cnt", done_cnt, 1);
        check("ignore_acc", acc, 8'h00);

        // Reset during the data phase of a store
        ldi(3);
        mem_ack = 1'b1;
        issue(1, 0, 1, 0, 3);
        next_cycle();
        mem_ack = 1'b0;
        check("pre_rst_we", mem_we, 1'b1);
        reset = 1'b0;
        #1;
        check("mid_rst_req", mem_req, 1'b0);
        check("mid_rst_we", mem_we, 1'b0);
        check("mid_rst_ad", addr_data, 1'b0);
        check("mid_rst_done", done, 1'b0);
        check("mid_rst_acc", acc, 8'h00);
        check("mid_rst_busy", busy, 1'b0);
        repeat (2) next_cycle();
        reset = 1'b1;
        issue(1, 0, 1, 0, 3);
        check("post_rst_r3", bus_out, 8'h00);
        mem_ack = 1'b1;
        repeat (2) next_cycle();
        check("post_rst_done", done, 1'b1);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            next_cycle();
            start     = ($urandom_range(0, 2) != 0);
            is_mem_op = ($urandom_range(0, 3) == 0);
            is_alu_op = 1'($urandom);
            mem_rw    = 1'($urandom);
            imm       = 3'($urandom);
            register  = 3'($urandom);
            data_in   = 8'($urandom);
            mem_ack   = ($urandom_range(0, 9) < 7);
        end
        next_cycle();
        start = 1'b0;
        repeat (2) next_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
